// File: rtl/serial_command_rx.sv
// serial_command_rx: 16x-oversampled UART receiver feeding an ASCII command parser that
// drives the error-injection controls. Define SERIAL_CMD_PARITY_EN for 8E1 framing (default 8N1).
module serial_command_rx #(
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       SERIAL_IN,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       FRAME_ERR,
    output logic [1:0] ERROR_TARGET_SELECT,
    output logic [3:0] ERROR_TYPE_SELECT,
    output logic       START,
    output logic       INHIBIT,
    output logic       CMD_ERROR
);
    localparam int TW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);

    localparam logic [1:0] CMD_T = 2'd0;
    localparam logic [1:0] CMD_E = 2'd1;
    localparam logic [1:0] CMD_I = 2'd2;

    typedef enum logic [2:0] {
        S_WAIT_HIGH,
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_CMD_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } rx_state_e;

    typedef enum logic {P_CMD, P_ARG} p_state_e;

    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
        if (b >= 8'h41 && b <= 8'h46) return {1'b1, b[3:0] + 4'd9};
        return 5'd0;
    endfunction

    logic            rx_meta_q, rx_s_q;
    logic [1:0]      flush_q;
    logic            sync_primed;
    logic [TW-1:0]   tick_cnt_q;
    logic            tick;
    logic [SW-1:0]   samp_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_ok;
    rx_state_e       rx_state_q, rx_state_d;
    logic            mid_start, bit_end;
    logic            clr_tick, samp_clr, bit_clr, shift_en, stop_ok, stop_bad;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q, frame_err_q;

    // The sync flops' reset value is not line data, so WAIT_HIGH ignores rx_s until they flush.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            flush_q   <= 2'b00;
        end else begin
            rx_meta_q <= SERIAL_IN;
            rx_s_q    <= rx_meta_q;
            flush_q   <= {flush_q[0], 1'b1};
        end
    end
    assign sync_primed = flush_q[1];

    assign tick      = (tick_cnt_q == TW'(BAUD_DIV - 1));
    assign mid_start = tick && (samp_cnt_q == SW'(OVERSAMPLE / 2 - 1));
    assign bit_end   = tick && (samp_cnt_q == SW'(OVERSAMPLE - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            if (clr_tick || tick) tick_cnt_q <= '0;
            else                  tick_cnt_q <= tick_cnt_q + 1'b1;
            if (samp_clr)  samp_cnt_q <= '0;
            else if (tick) samp_cnt_q <= samp_cnt_q + 1'b1;
            if (bit_clr)       bit_cnt_q <= '0;
            else if (shift_en) bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (shift_en) shift_q <= {rx_s_q, shift_q[7:1]};
    end

`ifdef SERIAL_CMD_PARITY_EN
    logic par_en, par_bit_q;
    always_ff @(posedge CLK) begin
        if (par_en) par_bit_q <= rx_s_q;
    end
    assign par_ok = ~(^shift_q ^ par_bit_q);
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) rx_state_q <= S_WAIT_HIGH;
        else          rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            S_WAIT_HIGH: if (sync_primed && rx_s_q) rx_state_d = S_IDLE;
            S_IDLE:      if (!rx_s_q) rx_state_d = S_START;
            S_START:     if (mid_start) rx_state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA: begin
                if (bit_end && bit_cnt_q == 3'd7) begin
`ifdef SERIAL_CMD_PARITY_EN
                    rx_state_d = S_PARITY;
`else
                    rx_state_d = S_STOP;
`endif
                end
            end
`ifdef SERIAL_CMD_PARITY_EN
            S_PARITY:    if (bit_end) rx_state_d = S_STOP;
`endif
            S_STOP:      if (bit_end) rx_state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
            default:     rx_state_d = S_WAIT_HIGH;
        endcase
    end

    always_comb begin
        clr_tick = 1'b0;
        samp_clr = 1'b0;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
`ifdef SERIAL_CMD_PARITY_EN
        par_en   = 1'b0;
`endif
        case (rx_state_q)
            S_IDLE: begin
                clr_tick = !rx_s_q;
                samp_clr = 1'b1;
            end
            S_START: begin
                samp_clr = mid_start;
                bit_clr  = 1'b1;
            end
            S_DATA: begin
                samp_clr = bit_end;
                shift_en = bit_end;
            end
`ifdef SERIAL_CMD_PARITY_EN
            S_PARITY: begin
                samp_clr = bit_end;
                par_en   = bit_end;
            end
`endif
            S_STOP: begin
                samp_clr = bit_end;
                stop_ok  = bit_end && rx_s_q && par_ok;
                stop_bad = bit_end && !(rx_s_q && par_ok);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= stop_ok;
            frame_err_q <= stop_bad;
            if (stop_ok) rx_data_q <= shift_q;
        end
    end

    p_state_e    p_state_q, p_state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [1:0]  targ_q, targ_d;
    logic [3:0]  type_q, type_d;
    logic        inh_q, inh_d;
    logic        start_q, start_d;
    logic        cmd_err_q, cmd_err_d;
    logic [4:0]  hex;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            p_state_q <= P_CMD;
            cmd_q     <= CMD_T;
            targ_q    <= 2'd0;
            type_q    <= 4'd0;
            inh_q     <= 1'b0;
            start_q   <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            cmd_q     <= cmd_d;
            targ_q    <= targ_d;
            type_q    <= type_d;
            inh_q     <= inh_d;
            start_q   <= start_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    always_comb begin
        p_state_d = p_state_q;
        if (p_state_q == P_ARG && frame_err_q) begin
            p_state_d = P_CMD;
        end else if (rx_valid_q) begin
            if (p_state_q == P_ARG) p_state_d = P_CMD;
            else if (rx_data_q == 8'h54 || rx_data_q == 8'h45 || rx_data_q == 8'h49) p_state_d = P_ARG;
        end
    end

    always_comb begin
        cmd_d     = cmd_q;
        targ_d    = targ_q;
        type_d    = type_q;
        inh_d     = inh_q;
        start_d   = 1'b0;
        cmd_err_d = 1'b0;
        hex       = hex_decode(rx_data_q);
        if (rx_valid_q) begin
            if (p_state_q == P_CMD) begin
                case (rx_data_q)
                    8'h54:               cmd_d = CMD_T;
                    8'h45:               cmd_d = CMD_E;
                    8'h49:               cmd_d = CMD_I;
                    8'h47:               start_d = 1'b1;
                    8'h0D, 8'h0A, 8'h20: ;
                    default:             cmd_err_d = 1'b1;
                endcase
            end else begin
                case (cmd_q)
                    CMD_T: begin
                        if (hex[4] && hex[3:0] <= 4'd3) targ_d = hex[1:0];
                        else cmd_err_d = 1'b1;
                    end
                    CMD_E: begin
                        if (hex[4]) type_d = hex[3:0];
                        else cmd_err_d = 1'b1;
                    end
                    default: begin
                        if (hex[4] && hex[3:0] <= 4'd1) inh_d = hex[0];
                        else cmd_err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    assign RX_DATA             = rx_data_q;
    assign RX_VALID            = rx_valid_q;
    assign FRAME_ERR           = frame_err_q;
    assign ERROR_TARGET_SELECT = targ_q;
    assign ERROR_TYPE_SELECT   = type_q;
    assign START               = start_q;
    assign INHIBIT             = inh_q;
    assign CMD_ERROR           = cmd_err_q;
endmodule

// File: tb/tb_serial_command_rx.sv
// Directed testbench for serial_command_rx: 8N1 frames at BAUD_DIV=4 / OVERSAMPLE=16 (64 clocks per bit).
module tb_serial_command_rx;
    localparam int BAUD_DIV   = 4;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = BAUD_DIV * OVERSAMPLE;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       SERIAL_IN = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic [1:0] ERROR_TARGET_SELECT;
    logic [3:0] ERROR_TYPE_SELECT;
    logic       START;
    logic       INHIBIT;
    logic       CMD_ERROR;

    serial_command_rx #(.BAUD_DIV(BAUD_DIV), .OVERSAMPLE(OVERSAMPLE)) dut (
        .CLK                 (CLK),
        .RESET_N             (RESET_N),
        .SERIAL_IN           (SERIAL_IN),
        .RX_DATA             (RX_DATA),
        .RX_VALID            (RX_VALID),
        .FRAME_ERR           (FRAME_ERR),
        .ERROR_TARGET_SELECT (ERROR_TARGET_SELECT),
        .ERROR_TYPE_SELECT   (ERROR_TYPE_SELECT),
        .START               (START),
        .INHIBIT             (INHIBIT),
        .CMD_ERROR           (CMD_ERROR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Strobe monitor, sampled on the falling edge
    int         n_valid = 0, n_ferr = 0, n_start = 0, n_cmderr = 0;
    int         start_wide = 0, start_lat_bad = 0;
    logic [7:0] last_data = 8'h00;
    logic       prev_valid = 1'b0, prev_start = 1'b0;
    logic [1:0] targ_after_valid = 2'd0;

    always @(negedge CLK) begin
        if (RX_VALID) begin
            n_valid++;
            last_data = RX_DATA;
        end
        if (prev_valid) targ_after_valid = ERROR_TARGET_SELECT;
        if (FRAME_ERR) n_ferr++;
        if (CMD_ERROR) n_cmderr++;
        if (START) begin
            n_start++;
            if (prev_start) start_wide++;
            if (!prev_valid) start_lat_bad++;
        end
        prev_valid = RX_VALID;
        prev_start = START;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        SERIAL_IN = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            SERIAL_IN = b[i];
            wait_clks(BIT_CLKS);
        end
        SERIAL_IN = stop_bit;
        wait_clks(BIT_CLKS);
        SERIAL_IN = 1'b1;
        wait_clks(16);
    endtask

    function automatic logic [31:0] all_outs();
        return {14'd0, RX_DATA, RX_VALID, FRAME_ERR, ERROR_TARGET_SELECT,
                ERROR_TYPE_SELECT, START, INHIBIT, CMD_ERROR};
    endfunction

    initial begin
        // Power-on reset with an idle line
        RESET_N   = 1'b0;
        SERIAL_IN = 1'b1;
        wait_clks(5);
        check("reset_outputs", all_outs(), 32'd0);
        RESET_N = 1'b1;
        wait_clks(10);

        // 'T','2' selects target 2
        send_byte(8'h54, 1'b1);
        check("T_valid_count", n_valid, 1);
        check("T_rx_data", last_data, 8'h54);
        send_byte(8'h32, 1'b1);
        check("2_valid_count", n_valid, 2);
        check("2_rx_data", last_data, 8'h32);
        check("target_one_cycle_after_valid", targ_after_valid, 2'd2);
        check("target_held", ERROR_TARGET_SELECT, 2'd2);
        check("no_cmd_error_T2", n_cmderr, 0);

        // 'E','B','G' sets type 0xB and fires one start strobe
        send_byte(8'h45, 1'b1);
        send_byte(8'h42, 1'b1);
        check("type_B", ERROR_TYPE_SELECT, 4'hB);
        check("no_start_before_G", n_start, 0);
        send_byte(8'h47, 1'b1);
        check("start_count", n_start, 1);
        check("start_single_cycle", start_wide, 0);
        check("start_latency", start_lat_bad, 0);
        check("valid_count_EBG", n_valid, 5);

        // Out-of-range 'T','5' then lowercase 'x'
        send_byte(8'h54, 1'b1);
        send_byte(8'h35, 1'b1);
        send_byte(8'h78, 1'b1);
        check("cmd_error_count", n_cmderr, 2);
        check("target_unchanged", ERROR_TARGET_SELECT, 2'd2);
        check("valid_count_T5x", n_valid, 8);

        // 'G' with a zero stop bit: frame error only
        send_byte(8'h47, 1'b0);
        check("frame_err_count", n_ferr, 1);
        check("no_valid_on_bad_stop", n_valid, 8);
        check("no_start_on_bad_stop", n_start, 1);
        check("rx_data_kept", RX_DATA, 8'h78);
        send_byte(8'h49, 1'b1);
        send_byte(8'h31, 1'b1);
        check("inhibit_set", INHIBIT, 1'b1);
        check("valid_count_I1", n_valid, 10);

        // Short low glitch, under half a bit
        SERIAL_IN = 1'b0;
        wait_clks(20);
        SERIAL_IN = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_no_valid", n_valid, 10);
        check("glitch_no_ferr", n_ferr, 1);
        check("glitch_no_start", n_start, 1);
        check("glitch_no_cmderr", n_cmderr, 2);
        send_byte(8'h45, 1'b1);
        send_byte(8'h33, 1'b1);
        check("type_3", ERROR_TYPE_SELECT, 4'h3);
        check("valid_count_E3", n_valid, 12);

        // Reset in the middle of a data bit with the line low
        SERIAL_IN = 1'b0;
        wait_clks(BIT_CLKS + 2 * BIT_CLKS + BIT_CLKS / 2);
        RESET_N = 1'b0;
        wait_clks(5);
        check("midframe_reset_outputs", all_outs(), 32'd0);
        RESET_N = 1'b1;
        wait_clks(700);
        check("no_valid_while_low", n_valid, 12);
        check("regs_cleared_after_reset", {ERROR_TARGET_SELECT, ERROR_TYPE_SELECT, INHIBIT}, 7'd0);
        SERIAL_IN = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("no_valid_after_line_high", n_valid, 12);
        send_byte(8'h54, 1'b1);
        send_byte(8'h31, 1'b1);
        check("valid_count_after_reset", n_valid, 14);
        check("rx_data_after_reset", last_data, 8'h31);
        check("target_1_after_reset", ERROR_TARGET_SELECT, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_command_rx.md
Name: serial_command_rx

Overview:
- UART receive path plus ASCII command parser. Lets the bench PC drive the error-injection controls that currently come from slide and push switches.
- Sits upstream of the ERROR block and MONITOR_SHIFTER inhibit input, alongside the existing TX UART.
- The top level muxes its ERROR_TARGET_SELECT / ERROR_TYPE_SELECT / START / INHIBIT outputs against the switch equivalents.
- Frame: 8N1, LSB first, 16x oversampled.

Parameters:
BAUD_DIV, 27, clk_int cycles per oversample tick (50 MHz / (115200*16) ≈ 27); legal range ≥2.
OVERSAMPLE, 16, ticks per bit; must be even, ≥8.

Ports:
CLK  in  1  system clock (clk_int)
RESET_N  in  1  asynchronous active-low reset
SERIAL_IN  in  1  raw RX line from PC, idle high, asynchronous
RX_DATA  out  8  last good received byte
RX_VALID  out  1  1-cycle strobe, RX_DATA valid
FRAME_ERR  out  1  1-cycle strobe, bad stop bit (or parity)
ERROR_TARGET_SELECT  out  2  commanded target
ERROR_TYPE_SELECT  out  4  commanded error type
START  out  1  1-cycle start strobe
INHIBIT  out  1  commanded monitor inhibit level
CMD_ERROR  out  1  1-cycle strobe, illegal command or argument

Behaviour:
- Reset is decided: one clock; reset is asynchronous and active-low.
  - All outputs reset to 0.
  - Synchronizer flops reset to 1.
  - RX FSM resets to WAIT_HIGH; parser resets to P_CMD.
- Synchronizer: 2 flops on SERIAL_IN. All logic uses the synced value (rx_s), adding 2-cycle input latency.
- Tick generator:
  - Counter runs 0..BAUD_DIV-1 and emits tick on BAUD_DIV-1.
  - Free-running, but cleared on the IDLE→START transition so bit timing aligns to the start edge.
- RX FSM states: WAIT_HIGH, IDLE, START, DATA, [PARITY], STOP.
  - WAIT_HIGH: stay until rx_s=1, then IDLE. This prevents decoding a frame cut by reset.
  - IDLE: rx_s=0 → START; clear tick count and sample count.
  - START: at tick OVERSAMPLE/2, sample rx_s.
    - 1 → IDLE (glitch rejected, no strobe).
    - 0 → DATA with sample count cleared.
  - DATA: every OVERSAMPLE ticks, shift in rx_s LSB-first. After bit 7 → STOP (or PARITY).
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - 1 → RX_VALID=1 for one cycle, RX_DATA updated in the same cycle, → IDLE.
    - 0 → FRAME_ERR=1 for one cycle, RX_DATA unchanged, → WAIT_HIGH.
- Parser: consumes RX_VALID bytes. Registered outputs update on the cycle after the RX_VALID strobe (latency 1).
  - P_CMD, byte handling:
    - 'T' (0x54), 'E' (0x45), 'I' (0x49): latch cmd, → P_ARG.
    - 'G' (0x47): START=1 for one cycle.
    - 0x0D, 0x0A, 0x20: ignored.
    - Anything else: CMD_ERROR pulse.
  - P_ARG: hex digit 0x30-0x39 or 0x41-0x46 decodes to value v.
    - T: requires v≤3, sets ERROR_TARGET_SELECT=v[1:0].
    - E: sets ERROR_TYPE_SELECT=v[3:0].
    - I: requires v≤1, sets INHIBIT=v[0].
    - Illegal or out-of-range argument: CMD_ERROR pulse, register unchanged.
    - Always returns to P_CMD.
  - Lowercase letters are illegal.
  - FRAME_ERR while in P_ARG: parser aborts to P_CMD, no CMD_ERROR.
- START is never asserted for more than one cycle per 'G'. Back-to-back 'G' bytes give separate strobes, at least one frame apart.
- Registers hold their values indefinitely. Only a new command or reset changes them.

Optional Feature:
SERIAL_CMD_PARITY_EN
- Defined:
  - Frame is 8E1. PARITY state samples a 9th bit.
  - If the even-parity check over data+parity fails, FRAME_ERR pulses at the stop sample (even when the stop bit is good), RX_VALID does not fire, and the FSM goes to IDLE (or to WAIT_HIGH if the stop bit is also 0).
- Undefined: 8N1 only; PARITY state and its logic are absent.

Test Plan (BAUD_DIV=4, OVERSAMPLE=16, 64 clocks/bit):
- Reset with SERIAL_IN=1, then send 'T','2' → one RX_VALID each with RX_DATA=0x54 then 0x32; ERROR_TARGET_SELECT=2 one cycle after the second RX_VALID; CMD_ERROR never set.
- Send 'E','B','G' → ERROR_TYPE_SELECT=4'hB; START high exactly 1 cycle, one cycle after the 'G' RX_VALID.
- Send 'T','5' then 'x' → two CMD_ERROR pulses; ERROR_TARGET_SELECT holds its prior value 2.
- Send 0x47 with stop bit forced 0 → FRAME_ERR pulse, no RX_VALID, no START; a following good 'I','1' sets INHIBIT=1.
- Drive SERIAL_IN low for 20 clocks (under half a bit), then high → no strobes of any kind; a subsequent 'E','3' decodes correctly.
- Assert RESET_N low mid-data-bit while SERIAL_IN=0, release with the line still low → no RX_VALID until the line goes high and a full new frame arrives; all outputs read 0 after reset.
